// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: two SRAM-like masters (inst = id 0, data = id 1) onto one slave port.
// Optional macro ARB_RR_EN selects round-robin tie-breaking; without it the data master wins ties.
module sram_like_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          inst_req,
    input  logic                          inst_wr,
    input  logic [1:0]                    inst_size,
    input  logic [ADDR_W-1:0]             inst_addr,
    input  logic [DATA_W/8-1:0]           inst_wstrb,
    input  logic [DATA_W-1:0]             inst_wdata,
    output logic                          inst_addr_ok,
    output logic                          inst_data_ok,
    output logic [DATA_W-1:0]             inst_rdata,

    input  logic                          data_req,
    input  logic                          data_wr,
    input  logic [1:0]                    data_size,
    input  logic [ADDR_W-1:0]             data_addr,
    input  logic [DATA_W/8-1:0]           data_wstrb,
    input  logic [DATA_W-1:0]             data_wdata,
    output logic                          data_addr_ok,
    output logic                          data_data_ok,
    output logic [DATA_W-1:0]             data_rdata,

    output logic                          mem_req,
    output logic                          mem_wr,
    output logic [1:0]                    mem_size,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W/8-1:0]           mem_wstrb,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_addr_ok,
    input  logic                          mem_data_ok,
    input  logic [DATA_W-1:0]             mem_rdata,

    output logic [$clog2(OUTSTANDING):0]  outstanding_cnt
);

    // Handshake: a request transfers on a cycle where req (valid) and addr_ok (ready) are both
    // high; responses are single-cycle data_ok pulses returned strictly in request order.

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic                   locked_q, locked_d;
    logic                   locked_id_q, locked_id_d;
    logic [OUTSTANDING-1:0] fifo_id_q;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic grant_id;
    logic grant_req;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic head_id;

`ifdef ARB_RR_EN
    logic last_grant_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b0;
        end else if (push) begin
            last_grant_q <= grant_id;
        end
    end
`endif

    assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head_id    = fifo_id_q[rd_ptr_q];

    // A pending address handshake pins the grant so mem_* stays stable until accepted.
    always_comb begin
        grant_id = 1'b0;
        if (locked_q) begin
            grant_id = locked_id_q;
        end else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
            grant_id = ~last_grant_q;
`else
            grant_id = 1'b1;
`endif
        end else if (data_req) begin
            grant_id = 1'b1;
        end
    end

    always_comb begin
        grant_req = inst_req;
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
        if (grant_id) begin
            grant_req = data_req;
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end
    end

    assign mem_req      = grant_req & ~fifo_full;
    assign push         = mem_req & mem_addr_ok;
    assign pop          = mem_data_ok & ~fifo_empty;

    assign inst_addr_ok = push & ~grant_id;
    assign data_addr_ok = push & grant_id;

    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop & head_id;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign outstanding_cnt = cnt_q;

    always_comb begin
        locked_d    = locked_q;
        locked_id_d = locked_id_q;
        if (mem_addr_ok) begin
            locked_d = 1'b0;
        end else if (mem_req) begin
            locked_d    = 1'b1;
            locked_id_d = grant_id;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q    <= 1'b0;
            locked_id_q <= 1'b0;
        end else begin
            locked_q    <= locked_d;
            locked_id_q <= locked_id_d;
        end
    end

    // Pointers are PTR_W bits wide, so they wrap modulo OUTSTANDING on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_id_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            if (push) begin
                fifo_id_q[wr_ptr_q] <= grant_id;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_sram_like_arbiter;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int OUTSTANDING = 4;
  localparam int CNT_W       = 3;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                 inst_req, inst_wr, data_req, data_wr;
  logic [1:0]           inst_size, data_size;
  logic [ADDR_W-1:0]    inst_addr, data_addr;
  logic [DATA_W/8-1:0]  inst_wstrb, data_wstrb;
  logic [DATA_W-1:0]    inst_wdata, data_wdata;
  logic                 inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DATA_W-1:0]    inst_rdata, data_rdata;
  logic                 mem_req, mem_wr;
  logic [1:0]           mem_size;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W/8-1:0]  mem_wstrb;
  logic [DATA_W-1:0]    mem_wdata;
  logic                 mem_addr_ok, mem_data_ok;
  logic [DATA_W-1:0]    mem_rdata;
  logic [CNT_W-1:0]     outstanding_cnt;

  sram_like_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .outstanding_cnt(outstanding_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: ids of accepted, not yet answered requests, oldest first
  logic [0:0] exp_q[$];
  bit m_locked;
  bit m_lid;
  bit m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decide who owns the slave port, then derive every output from that.
  task automatic model_check();
    bit who, want, exp_req, acc, pop, head;
    if (reset) begin
      exp_q.delete();
      m_locked = 1'b0;
      m_lid    = 1'b0;
      m_last   = 1'b0;
      return;
    end
    if (m_locked) who = m_lid;
    else if (inst_req && data_req) who = RR ? !m_last : 1'b1;
    else who = data_req;
    want    = who ? data_req : inst_req;
    exp_req = want && (exp_q.size() < OUTSTANDING);
    acc     = exp_req && mem_addr_ok;
    pop     = mem_data_ok && (exp_q.size() > 0);
    head    = pop ? exp_q[0][0] : 1'b0;

    chk("mem_req", 64'(mem_req), 64'(exp_req));
    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(acc && !who));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(acc && who));
    chk("inst_data_ok", 64'(inst_data_ok), 64'(pop && !head));
    chk("data_data_ok", 64'(data_data_ok), 64'(pop && head));
    chk("outstanding_cnt", 64'(outstanding_cnt), 64'(exp_q.size()));
    if (exp_req) begin
      chk("mem_addr", 64'(mem_addr), 64'(who ? data_addr : inst_addr));
      chk("mem_wr", 64'(mem_wr), 64'(who ? data_wr : inst_wr));
      chk("mem_size", 64'(mem_size), 64'(who ? data_size : inst_size));
      chk("mem_wstrb", 64'(mem_wstrb), 64'(who ? data_wstrb : inst_wstrb));
      chk("mem_wdata", 64'(mem_wdata), 64'(who ? data_wdata : inst_wdata));
    end
    if (pop) chk("rdata", 64'(head ? data_rdata : inst_rdata), 64'(mem_rdata));

    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(who);
      m_last = who;
    end
    if (mem_addr_ok) m_locked = 1'b0;
    else if (exp_req) begin
      m_locked = 1'b1;
      m_lid    = who;
    end
  endtask

  // driver tasks
  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) begin
      mem_data_ok = 1; mem_rdata = $urandom;
      cycle();
    end
    mem_data_ok = 0;
  endtask

  task automatic randomize_inputs();
    inst_req   = 1'($urandom_range(0, 1));
    inst_wr    = 1'($urandom_range(0, 1));
    inst_size  = 2'($urandom_range(0, 2));
    inst_addr  = $urandom;
    inst_wstrb = 4'($urandom);
    inst_wdata = $urandom;
    data_req   = 1'($urandom_range(0, 1));
    data_wr    = 1'($urandom_range(0, 1));
    data_size  = 2'($urandom_range(0, 2));
    data_addr  = $urandom;
    data_wstrb = 4'($urandom);
    data_wdata = $urandom;
    mem_addr_ok = ($urandom_range(0, 3) != 0);
    mem_data_ok = ($urandom_range(0, 2) == 0);
    mem_rdata   = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1;
    tick(); cycle(); cycle();
    reset = 0;
    settle();
    chk("reset_cnt", 64'(outstanding_cnt), 64'd0);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    tick();

    // single inst read, response two cycles later
    inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
    settle();
    chk("t1_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h1c00_0000);
    tick();
    idle(); cycle();
    mem_data_ok = 1; mem_rdata = 32'h1234_5678;
    settle();
    chk("t1_inst_data_ok", 64'(inst_data_ok), 64'd1);
    chk("t1_inst_rdata", 64'(inst_rdata), 64'h1234_5678);
    chk("t1_data_data_ok", 64'(data_data_ok), 64'd0);
    tick();

    // both request every cycle; responses drain at the same rate
    idle();
    for (int i = 0; i < 4; i++) begin
      inst_req = 1; data_req = 1; inst_addr = 32'h100 + i; data_addr = 32'h200 + i;
      mem_addr_ok = 1; mem_data_ok = 1;
      settle();
      chk("t2_data_addr_ok", 64'(data_addr_ok), 64'(RR ? (i % 2 == 0) : 1'b1));
      chk("t2_inst_addr_ok", 64'(inst_addr_ok), 64'(RR ? (i % 2 == 1) : 1'b0));
      tick();
    end
    drain(1);

    // address handshake stalls for three cycles; data arrives while locked
    idle();
    inst_req = 1; inst_addr = 32'h2000_0000;
    for (int i = 0; i < 3; i++) begin
      if (i >= 1) begin data_req = 1; data_addr = 32'h3000_0000; end
      settle();
      chk("t3_mem_addr_locked", 64'(mem_addr), 64'h2000_0000);
      chk("t3_data_addr_ok", 64'(data_addr_ok), 64'd0);
      tick();
    end
    mem_addr_ok = 1;
    settle();
    chk("t3_inst_accept", 64'(inst_addr_ok), 64'd1);
    tick();
    inst_req = 0;
    settle();
    chk("t3_data_accept", 64'(data_addr_ok), 64'd1);
    tick();
    drain(2);

    // fill the order FIFO, then free one slot
    idle();
    for (int i = 0; i < 4; i++) begin
      inst_req = 1; inst_addr = 32'h400 + 4 * i; mem_addr_ok = 1;
      cycle();
    end
    mem_data_ok = 1; mem_rdata = 32'h55;
    settle();
    chk("t4_full_mem_req", 64'(mem_req), 64'd0);
    chk("t4_full_cnt", 64'(outstanding_cnt), 64'd4);
    chk("t4_full_addr_ok", 64'(inst_addr_ok), 64'd0);
    chk("t4_pop_data_ok", 64'(inst_data_ok), 64'd1);
    tick();
    mem_data_ok = 0;
    settle();
    chk("t4_fifth_accept", 64'(inst_addr_ok), 64'd1);
    tick();
    drain(4);

    // in-order response steering
    idle();
    inst_req = 1; mem_addr_ok = 1; cycle();
    inst_req = 0; data_req = 1; cycle();
    data_req = 0; inst_req = 1; cycle();
    idle(); mem_data_ok = 1;
    mem_rdata = 32'hA; settle();
    chk("t5_inst_A", 64'(inst_data_ok ? inst_rdata : 32'hFFFF_FFFF), 64'hA);
    tick();
    mem_rdata = 32'hB; settle();
    chk("t5_data_B", 64'(data_data_ok ? data_rdata : 32'hFFFF_FFFF), 64'hB);
    tick();
    mem_rdata = 32'hC; settle();
    chk("t5_inst_C", 64'(inst_data_ok ? inst_rdata : 32'hFFFF_FFFF), 64'hC);
    tick();

    // reset discards in-flight tracking
    idle();
    inst_req = 1; mem_addr_ok = 1; cycle();
    inst_req = 0; data_req = 1; cycle();
    idle(); reset = 1; cycle();
    reset = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD;
    settle();
    chk("t6_inst_data_ok", 64'(inst_data_ok), 64'd0);
    chk("t6_data_data_ok", 64'(data_data_ok), 64'd0);
    chk("t6_cnt", 64'(outstanding_cnt), 64'd0);
    tick();
    idle();
    settle();
    chk("t6_cnt_after", 64'(outstanding_cnt), 64'd0);
    tick();

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 0;
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
